motor_current_control: RTL and testbench

Back-end motor drive stage: consumes the 13-bit assistance requirement produced by the assistance calculator and turns it into a slew-limited PWM gate signal for the hub-motor bridge. Also monitors phase current samples from the current-sense ADC and latches an overcurrent fault that forces the motor off. Sits between the assistance calculator and the gate-driver pins.

---
 rtl/motor_current_control.sv | 153 +++++++++++++++
 tb/tb_motor_current_control.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/motor_current_control.sv
// Motor drive back end: slew-limited PWM duty from the assistance requirement plus overcurrent trip.
// Define OVERCURRENT_TRIP_EN to build the overcurrent monitor and FAULT state; otherwise fault is 0.
module motor_current_control #(
  parameter int unsigned PWM_BITS  = 10,
  parameter int unsigned RAMP_STEP = 8,
  parameter logic [11:0] OC_LIMIT  = 12'd3000,
  parameter int unsigned OC_COUNT  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [12:0]         assist_req,
  input  logic                enable,
  input  logic [11:0]         current_sample,
  input  logic                current_valid,
  input  logic                fault_clear,
  output logic                pwm_out,
  output logic [PWM_BITS-1:0] duty,
  output logic                period_start,
  output logic                fault
);

  typedef enum logic [1:0] {StIdle, StRamp, StHold, StFault} state_e;

  localparam logic [PWM_BITS:0] Step = (PWM_BITS + 1)'(RAMP_STEP);

  state_e              state_q, state_d;
  logic [PWM_BITS-1:0] cnt_q, duty_q, duty_d, target;
  logic [PWM_BITS:0]   duty_step;
  logic [PWM_BITS-1:0] ramp_sat, ramp_next;
  logic                pwm_q, period_start_q;
  logic                wrap, trip;

  assign wrap   = (cnt_q == {PWM_BITS{1'b1}});
  assign target = assist_req[12] ? {PWM_BITS{1'b1}} : assist_req[11 -: PWM_BITS];

  // Step computed one bit wide so it can saturate instead of wrapping.
  assign duty_step = {1'b0, duty_q} + Step;
  assign ramp_sat  = duty_step[PWM_BITS] ? {PWM_BITS{1'b1}} : duty_step[PWM_BITS-1:0];
  assign ramp_next = (ramp_sat < target) ? ramp_sat : target;

`ifdef OVERCURRENT_TRIP_EN
  localparam int unsigned OcW = $clog2(OC_COUNT + 1);

  logic [OcW-1:0] oc_cnt_q, oc_cnt_d;
  logic           over;

  assign over = (current_sample > OC_LIMIT);
  assign trip = current_valid && over && (oc_cnt_q == OcW'(OC_COUNT - 1));

  always_comb begin
    oc_cnt_d = oc_cnt_q;
    if (trip) begin
      oc_cnt_d = '0;
    end else if (current_valid) begin
      oc_cnt_d = over ? oc_cnt_q + OcW'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oc_cnt_q <= '0;
    end else begin
      oc_cnt_q <= oc_cnt_d;
    end
  end

  assign fault = (state_q == StFault);
`else
  logic unused_oc;
  assign unused_oc = ^{current_sample, current_valid, OC_LIMIT, OC_COUNT[0]};
  assign trip      = 1'b0;
  assign fault     = 1'b0;
`endif

  // Trip beats everything; an enable drop is honoured immediately, other changes only at wrap.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    if (trip) begin
      state_d = StFault;
      duty_d  = '0;
    end else begin
      case (state_q)
        StIdle: begin
          duty_d = '0;
          if (wrap && enable && (target != '0)) state_d = StRamp;
        end
        StRamp: begin
          if (!enable) begin
            state_d = StIdle;
            duty_d  = '0;
          end else if (wrap) begin
            if (target == '0) begin
              state_d = StIdle;
              duty_d  = '0;
            end else if (target <= duty_q) begin
              state_d = StHold;
              duty_d  = target;
            end else begin
              duty_d = ramp_next;
              if (ramp_next == target) state_d = StHold;
            end
          end
        end
        StHold: begin
          if (!enable) begin
            state_d = StIdle;
            duty_d  = '0;
          end else if (wrap) begin
            if (target == '0) begin
              state_d = StIdle;
              duty_d  = '0;
            end else if (target > duty_q) begin
              state_d = StRamp;
            end else begin
              duty_d = target;
            end
          end
        end
        StFault: begin
          duty_d = '0;
          if (fault_clear && (assist_req == '0)) state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
          duty_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      duty_q         <= '0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_q + PWM_BITS'(1);
      duty_q         <= duty_d;
      // cnt==max never beats any duty, so using duty_d only matters for the forced-off cases.
      pwm_q          <= (cnt_q < duty_d);
      period_start_q <= (cnt_q == '0);
    end
  end

  assign pwm_out      = pwm_q;
  assign duty         = duty_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_motor_current_control.sv
// Bench for motor_current_control: directed scenarios and random traffic checked every cycle
// against a behavioural model of duty ramping, overcurrent trip and fault recovery.
module tb_motor_current_control;

  localparam int Period = 1024;
`ifdef OVERCURRENT_TRIP_EN
  localparam bit OcEn = 1'b1;
`else
  localparam bit OcEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] assist_req;
  logic        enable;
  logic [11:0] current_sample;
  logic        current_valid;
  logic        fault_clear;
  logic        pwm_out;
  logic [9:0]  duty;
  logic        period_start;
  logic        fault;

  int n_checks = 0;
  int n_errors = 0;
  int hi_cnt   = 0;
  int ps_cnt   = 0;

  // Model state: duty as a number, plus whether the drive is engaged / still climbing / faulted.
  int m_cnt, m_duty, m_oc;
  bit m_pwm, m_ps, m_faulted, m_engaged, m_climbing;

  motor_current_control dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .assist_req     (assist_req),
    .enable         (enable),
    .current_sample (current_sample),
    .current_valid  (current_valid),
    .fault_clear    (fault_clear),
    .pwm_out        (pwm_out),
    .duty           (duty),
    .period_start   (period_start),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int target_of(input logic [12:0] a);
    return a[12] ? 1023 : int'(a[11:2]);
  endfunction

  task automatic model_step();
    int tgt, old_cnt, old_duty;
    bit over, trip;
    if (!rst_n) begin
      m_cnt = 0; m_duty = 0; m_oc = 0;
      m_pwm = 0; m_ps = 0; m_faulted = 0; m_engaged = 0; m_climbing = 0;
      return;
    end
    tgt      = target_of(assist_req);
    old_cnt  = m_cnt;
    old_duty = m_duty;
    over     = (current_sample > 12'd3000);
    trip     = OcEn && current_valid && over && (m_oc + 1 >= 3);
    if (OcEn && current_valid) m_oc = over ? m_oc + 1 : 0;
    if (trip) begin
      m_oc = 0; m_faulted = 1; m_engaged = 0; m_climbing = 0; m_duty = 0;
    end else if (m_faulted) begin
      if (fault_clear && assist_req == 0) m_faulted = 0;
    end else if (m_engaged && !enable) begin
      m_engaged = 0; m_climbing = 0; m_duty = 0;
    end else if (old_cnt == Period - 1) begin
      if (!m_engaged) begin
        if (enable && tgt > 0) begin
          m_engaged = 1; m_climbing = 1;
        end
      end else if (tgt == 0) begin
        m_engaged = 0; m_climbing = 0; m_duty = 0;
      end else if (m_climbing) begin
        m_duty     = (m_duty + 8 < tgt) ? m_duty + 8 : tgt;
        m_climbing = (m_duty != tgt);
      end else if (tgt > m_duty) begin
        m_climbing = 1;
      end else begin
        m_duty = tgt;
      end
    end
    m_pwm = (m_duty != 0) && (old_cnt < old_duty);
    m_ps  = (old_cnt == 0);
    m_cnt = (old_cnt + 1) % Period;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("pwm_out", pwm_out, m_pwm);
    check("duty", duty, m_duty);
    check("period_start", period_start, m_ps);
    check("fault", fault, m_faulted);
    hi_cnt += pwm_out;
    ps_cnt += period_start;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input int sample);
    current_sample = 12'(sample);
    current_valid  = 1'b1;
    tick();
    current_valid  = 1'b0;
  endtask

  task automatic clear_pulse();
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; assist_req = '0; enable = 1'b0;
    current_sample = '0; current_valid = 1'b0; fault_clear = 1'b0;
    run(3);
    check("reset duty", duty, 0);
    check("reset pwm", pwm_out, 0);
    rst_n  = 1'b1;
    enable = 1'b1;

    // No assist: pwm stays low, one period_start per 1024 cycles.
    hi_cnt = 0; ps_cnt = 0;
    run(2 * Period);
    check("idle pwm highs", hi_cnt, 0);
    check("idle period starts", ps_cnt, 2);

    // Ramp to target 160 in steps of 8, then hold.
    assist_req = 13'd640;
    run(23 * Period);
    check("ramp final duty", duty, 160);
    hi_cnt = 0;
    run(Period);
    check("hold pwm highs", hi_cnt, 160);

    // Lower target applies at the next wrap without ramping.
    assist_req = 13'd400;
    run(Period);
    check("step down duty", duty, 100);

    // Broken or at-limit runs do not trip.
    strobe(2999); strobe(3001); run(2); strobe(3001); strobe(2999); strobe(3001); run(2);
    check("no trip 3001,3001,2999,3001", fault, 0);
    strobe(2999); strobe(3001); strobe(3001); strobe(3000); run(2);
    check("no trip at limit", fault, 0);
    strobe(2999); strobe(3001); run(3); strobe(3001); run(3); strobe(3001);
    check("trip fault", fault, OcEn ? 1 : 0);
    check("trip duty", duty, OcEn ? 0 : 100);
    run(4);

    // Clearing is refused while assist is requested.
    clear_pulse();
    check("clear refused", fault, OcEn ? 1 : 0);
    assist_req = '0;
    clear_pulse();
    check("clear accepted", fault, 0);
    run(Period);

    // Enable drop mid-ramp forces off on the next cycle.
    assist_req = 13'd2048;
    run(3 * Period);
    run(Period - m_cnt + 2);
    check("ramp pwm high", pwm_out, 1);
    enable = 1'b0;
    tick();
    check("enable drop pwm", pwm_out, 0);
    check("enable drop duty", duty, 0);
    run(Period);
    check("idle after drop", duty, 0);
    enable = 1'b1;

    // Sustained worst-case current.
    for (int i = 0; i < 5; i++) strobe(4095);
    check("4095 x5 fault", fault, OcEn ? 1 : 0);
    assist_req = '0;
    clear_pulse();
    check("recover after 4095", fault, 0);

    // Asynchronous reset mid-period.
    assist_req = 13'd2048;
    run(4 * Period + 300);
    #2 rst_n = 1'b0;
    #1;
    check("async reset pwm", pwm_out, 0);
    check("async reset duty", duty, 0);
    check("async reset period_start", period_start, 0);
    check("async reset fault", fault, 0);
    run(2);
    rst_n = 1'b1;
    run(Period);

    // Random traffic around the overcurrent threshold.
    for (int i = 0; i < 20 * Period; i++) begin
      current_valid = 1'b0;
      fault_clear   = 1'b0;
      if ($urandom_range(0, 499) == 0)
        assist_req = ($urandom_range(0, 3) == 0) ? 13'd0 : 13'($urandom_range(0, 8191));
      if ($urandom_range(0, 2999) == 0) enable = ~enable;
      if ($urandom_range(0, 15) == 0) begin
        current_valid  = 1'b1;
        current_sample = 12'($urandom_range(2994, 3006));
      end
      if ($urandom_range(0, 199) == 0) fault_clear = 1'b1;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
